// File: rtl/sbit_accum.sv
// sbit_accum: converts a unary stochastic bitstream back to binary.
// Counts the ones over a window of 2^WINLOG valid samples. The result is registered and
// offered on a valid/ready handshake.
// Build option SBIT_ACCUM_BIPOLAR_EN: when defined, the result is bipolar two's
// complement, (ones - 2^(WINLOG-1)) << (DATAWD-WINLOG). When undefined, the result is
// unipolar unsigned, ones << (DATAWD-WINLOG).
module sbit_accum #(
    parameter int unsigned DATAWD = 8,
    parameter int unsigned WINLOG = DATAWD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iStart,
    input  logic            iBit,
    input  logic            iBitValid,
    input  logic            iReady,
    output logic            oBusy,
    output logic            oValid,
    output logic [DATAWD:0] oResult
);

    localparam int unsigned CntW  = WINLOG + 1;
    localparam int unsigned ResW  = DATAWD + 1;
    localparam int unsigned Shift = DATAWD - WINLOG;

    // Window length; needs the extra counter bit to be representable.
    localparam logic [CntW-1:0] WinLen = CntW'(1) << WINLOG;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   ones_q, ones_d;
    logic [CntW-1:0]   samples_q, samples_d;
    logic [ResW-1:0]   result_q, result_d;
    logic              busy_q, valid_q;

    logic [CntW-1:0]   ones_inc;
    logic [CntW-1:0]   samples_inc;
    logic              last_sample;
    logic [ResW-1:0]   ones_ext;
    logic [ResW-1:0]   decoded;

    // Counts as they would stand after accepting the current sample.
    assign ones_inc    = ones_q + CntW'(iBit);
    assign samples_inc = samples_q + CntW'(1);
    assign last_sample = (samples_inc == WinLen);
    assign ones_ext    = ResW'(ones_inc);

`ifdef SBIT_ACCUM_BIPOLAR_EN
    localparam logic [ResW-1:0] HalfWin = ResW'(1) << (WINLOG - 1);

    // Offset to zero-centred two's complement; a left shift keeps the sign in modular math.
    assign decoded = (ones_ext - HalfWin) << Shift;
`else
    // Scale the count up to the full-scale 2^DATAWD range.
    assign decoded = ones_ext << Shift;
`endif

    // Next-state, counter and result-load logic.
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        samples_d = samples_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d   = StAccum;
                    ones_d    = '0;
                    samples_d = '0;
                end
            end
            StAccum: begin
                if (iBitValid) begin
                    ones_d    = ones_inc;
                    samples_d = samples_inc;
                    if (last_sample) begin
                        state_d  = StDone;
                        result_d = decoded;
                    end
                end
            end
            StDone: begin
                // Result is held until taken; a start request alongside the take
                // chains straight into the next window.
                if (iReady) begin
                    if (iStart) begin
                        state_d   = StAccum;
                        ones_d    = '0;
                        samples_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and registered outputs; reset discards any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ones_q    <= '0;
            samples_q <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            samples_q <= samples_d;
            result_q  <= result_d;
            busy_q    <= (state_d == StAccum);
            valid_q   <= (state_d == StDone);
        end
    end

    assign oBusy   = busy_q;
    assign oValid  = valid_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_sbit_accum.sv
// Bench for sbit_accum. Instance a uses DATAWD=8, WINLOG=8, and instance b uses
// DATAWD=8, WINLOG=4. Expected results are pushed when a window is issued. A monitor
// per instance pops and compares them when each result is taken.
`timescale 1ns/1ps
module tb_sbit_accum;

`ifdef SBIT_ACCUM_BIPOLAR_EN
    `define SB_PICK(u, b) (b)
`else
    `define SB_PICK(u, b) (u)
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_start, a_bit, a_bv, a_ready, a_busy, a_vo;
    logic [8:0] a_res;
    logic       b_start, b_bit, b_bv, b_ready, b_busy, b_vo;
    logic [8:0] b_res;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] qa[$];
    logic [8:0] qb[$];

    always #5 clk = ~clk;

    sbit_accum #(.DATAWD(8), .WINLOG(8)) u_a (
        .clk(clk), .rst_n(rst_n), .iStart(a_start), .iBit(a_bit), .iBitValid(a_bv),
        .iReady(a_ready), .oBusy(a_busy), .oValid(a_vo), .oResult(a_res)
    );

    sbit_accum #(.DATAWD(8), .WINLOG(4)) u_b (
        .clk(clk), .rst_n(rst_n), .iStart(b_start), .iBit(b_bit), .iBitValid(b_bv),
        .iReady(b_ready), .oBusy(b_busy), .oValid(b_vo), .oResult(b_res)
    );

    task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit patterns. 0: all ones. 1: alternating 1/0. 2: zeros. 3: every 4th sample set.
    // 4: first 200 set. 5: first 10 set. 6: first 5 set.
    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return 1'b1;
            1:       return (i % 2) == 0;
            2:       return 1'b0;
            3:       return (i % 4) == 0;
            4:       return i < 200;
            5:       return i < 10;
            6:       return i < 5;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard monitors: compare on every accepted result.
    always @(negedge clk) begin
        if (rst_n && a_vo && a_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_result: got 0x%0h, expected none", a_res);
            end else begin
                chk9("a_result", a_res, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_vo && b_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_result: got 0x%0h, expected none", b_res);
            end else begin
                chk9("b_result", b_res, qb.pop_front());
            end
        end
    end

    task automatic a_begin();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    // Feed n samples; with gap, an invalid cycle follows each sample except the last.
    // With chk_done, check that oValid is low before the last sample and high right after.
    // Combined with a_begin, a gapless window gives oValid exactly 2^WINLOG+1 cycles
    // after the start cycle.
    task automatic a_feed(input int kind, input int n, input bit gap, input bit chk_done);
        logic busy_ok;
        busy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            a_bv  = 1'b1;
            a_bit = pat(kind, i);
            if (a_busy !== 1'b1) busy_ok = 1'b0;
            if (chk_done && i == n - 1) chk1("a_valid_before_last", a_vo, 1'b0);
            step();
            if (gap && i != n - 1) begin
                a_bv  = 1'b0;
                a_bit = 1'b1;
                if (a_busy !== 1'b1) busy_ok = 1'b0;
                step();
            end
        end
        a_bv  = 1'b0;
        a_bit = 1'b0;
        if (chk_done) begin
            chk1("a_busy_in_window", busy_ok, 1'b1);
            chk1("a_valid_after_last", a_vo, 1'b1);
            chk1("a_busy_in_done", a_busy, 1'b0);
        end
    endtask

    task automatic a_accept();
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        chk1("a_valid_after_accept", a_vo, 1'b0);
        chk1("a_busy_after_accept", a_busy, 1'b0);
    endtask

    task automatic b_window(input int kind);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_bv  = 1'b1;
            b_bit = pat(kind, i);
            step();
        end
        b_bv  = 1'b0;
        b_bit = 1'b0;
        chk1("b_valid_after_last", b_vo, 1'b1);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        chk1("b_valid_after_accept", b_vo, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        a_start = 1'b0; a_bit = 1'b0; a_bv = 1'b0; a_ready = 1'b0;
        b_start = 1'b0; b_bit = 1'b0; b_bv = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("a_reset_busy", a_busy, 1'b0);
        chk1("a_reset_valid", a_vo, 1'b0);
        chk9("a_reset_result", a_res, 9'd0);
        chk1("b_reset_busy", b_busy, 1'b0);
        chk1("b_reset_valid", b_vo, 1'b0);
        chk9("b_reset_result", b_res, 9'd0);
        rst_n = 1'b1;
        step();

        // Full window of ones.
        qa.push_back(`SB_PICK(9'h100, 9'h080));
        a_begin();
        a_feed(0, 256, 1'b0, 1'b1);
        a_accept();

        // Alternating bits, then all zeros.
        qa.push_back(`SB_PICK(9'd128, 9'd0));
        a_begin();
        a_feed(1, 256, 1'b0, 1'b1);
        a_accept();
        qa.push_back(`SB_PICK(9'd0, 9'h180));
        a_begin();
        a_feed(2, 256, 1'b0, 1'b1);
        a_accept();

        // Valid on every other cycle, 64 ones among 256 valid samples.
        qa.push_back(`SB_PICK(9'd64, 9'h1C0));
        a_begin();
        a_feed(3, 256, 1'b1, 1'b1);
        a_accept();

        // Backpressure: result held while starts and bits are presented.
        qa.push_back(`SB_PICK(9'd200, 9'd72));
        a_begin();
        a_feed(4, 256, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            a_ready = 1'b0;
            a_start = k[0];
            a_bv    = 1'b1;
            a_bit   = 1'b1;
            step();
            chk1("a_hold_valid", a_vo, 1'b1);
            chk9("a_hold_result", a_res, `SB_PICK(9'd200, 9'd72));
        end
        // Take and restart in the same cycle; the new window counts from zero.
        qa.push_back(`SB_PICK(9'd10, 9'h18A));
        a_start = 1'b1;
        a_ready = 1'b1;
        a_bv    = 1'b0;
        a_bit   = 1'b0;
        step();
        a_start = 1'b0;
        a_ready = 1'b0;
        chk1("a_restart_busy", a_busy, 1'b1);
        chk1("a_restart_valid", a_vo, 1'b0);
        a_feed(5, 256, 1'b0, 1'b1);
        a_accept();

        // Reset in the middle of a window; no result for the partial window.
        a_begin();
        a_feed(0, 100, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("a_midreset_busy", a_busy, 1'b0);
        chk1("a_midreset_valid", a_vo, 1'b0);
        chk9("a_midreset_result", a_res, 9'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        qa.push_back(`SB_PICK(9'h100, 9'h080));
        a_begin();
        a_feed(0, 256, 1'b0, 1'b1);
        a_accept();

        // Short window instance.
        qb.push_back(`SB_PICK(9'd80, 9'h1D0));
        b_window(6);
        qb.push_back(`SB_PICK(9'h100, 9'h080));
        b_window(0);

        repeat (3) step();
        chk9("a_queue_drained", 9'(qa.size()), 9'd0);
        chk9("b_queue_drained", 9'(qb.size()), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
